fp_div_scheduler: RTL and testbench
===================================

# fp_div_scheduler

Shares one `fp_division_pipeline` instance among `NUM_REQ` independent requesters. The block arbitrates requests round-robin and issues at most one division per cycle into the divider. It tags each in-flight operation with its requester ID and steers each result into a small per-requester result FIFO. Per-requester credit accounting guarantees a result slot exists before issue, so the non-stallable divider never has to be back-pressured.

## Interface
- `NUM_REQ`, default 4: number of requesters (≥2).
- `LATENCY`, default 15: divider latency in cycles, from `div_valid_in` sampled high to `div_valid_out` high.
- `RESULT_DEPTH`, default 2: result FIFO entries per requester (≥1).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: request valid, one bit per requester.
- `req_ready` out NUM_REQ: request accepted this cycle when valid&ready.
- `req_in1` in NUM_REQ*32: dividends; requester i uses bits [32i+31:32i].
- `req_in2` in NUM_REQ*32: divisors, same packing as `req_in1`.
- `req_rounding_mode` in NUM_REQ*3: rounding mode per requester, 3 bits each.
- `div_valid_in`, `div_in1`, `div_in2`, `div_rounding_mode` out 1/32/32/3: registered drive to the divider.
- `div_out` in 32; `div_flags` in 5; `div_valid_out` in 1: divider results. `div_flags` = {invalid_operation, division_by_zero, overflow, underflow, inexact}.
- `rsp_valid` out NUM_REQ; `rsp_ready` in NUM_REQ: result handshake per requester.
- `rsp_data` out NUM_REQ*32; `rsp_flags` out NUM_REQ*5: FIFO head per requester.
- `tag_error` out 1: sticky; set on divider/tag mismatch.

## Operation
- **Credit.** Each requester has a counter `outstanding[i]` = in-flight operations + FIFO occupancy.
  - The counter is +1 on request accept and −1 on `rsp_valid&rsp_ready`. When both happen in the same cycle it is unchanged.
  - Width is clog2(RESULT_DEPTH+1).
  - Requester i is eligible when `req_valid[i]` is high and `outstanding[i] < RESULT_DEPTH`.
- **Arbitration.** Round-robin across eligible requesters, searching from `rr_ptr+1` with wrap-around.
  - `req_ready` is one-hot or zero. It may depend combinationally on `req_valid`.
  - `rr_ptr` updates to the granted index only on accept.
  - Requesters hold `req_*` stable until accepted.
- **Issue register.** On accept, the operands, rounding mode and `div_valid_in=1` are registered. Otherwise `div_valid_in=0` and the operand registers hold.
- **Tag pipeline.** A `LATENCY`-deep shift register of {valid, id} advances every cycle and is loaded from the issue register. Its tail is aligned with `div_valid_out`.
- **Result steering.**
  - When the tail is valid and `div_valid_out=1`, {`div_out`, `div_flags`} is pushed into FIFO[tail.id].
  - A FIFO can never be full at push time, because credit forbids it.
- **Mismatch.** If tail.valid ≠ `div_valid_out`:
  - `tag_error` is set.
  - Any unmatched result is dropped.
  - An unmatched tag releases its credit (−1).
- **FIFOs.**
  - `rsp_valid[i]` = FIFO[i] not empty; `rsp_data`/`rsp_flags` show the head.
  - Push and pop in the same cycle are both performed.
  - Push into an empty FIFO is visible the next cycle.

## Timing
- Reset values: all `req_ready`, `div_valid_in`, `rsp_valid` and `tag_error` = 0; `div_in1`/`div_in2`/`rsp_data` = 0; `div_rounding_mode`/`rsp_flags` = 0.
  - Internally: counters 0, `rr_ptr` = NUM_REQ−1 (so requester 0 has first priority), tags invalid, FIFOs empty.
- Latency: request accept at cycle t gives `div_valid_in` at t+1, `div_valid_out` at t+1+LATENCY, and `rsp_valid` at t+2+LATENCY.
- Throughput: one issue per cycle in aggregate. A single requester sustains RESULT_DEPTH issues per (LATENCY+2+pop delay) cycles.
- Reset mid-operation:
  - All in-flight tags and FIFO contents are discarded.
  - The divider shares `rst_n` (inverted to its active-high `rst`), so no stale `div_valid_out` follows.

## Structure
- Shared package `fp_pkg` additions:
  - `fp_div_flags_t` packed struct {nv, dz, of, uf, nx}.
  - `fp_div_result_t` {fp_32b_t value; fp_div_flags_t flags}.
- Sub-module `rr_arbiter #(N)`: request vector and pointer in, one-hot grant out, combinational.
- The FIFOs and tag pipeline are inline generate loops.

## Test plan
- **Single request.** Requester 0 sends 0x40C00000 / 0x40000000, RNE. Expect `rsp_data[0]` = 0x40400000 with flags 0, exactly LATENCY+2 cycles after accept.
- **Fairness.** All 4 requesters held valid with `rsp_ready` = 1. Grants go 0,1,2,3,0,… with one accept per cycle, and each result returns to its issuer in order.
- **Credit stall.** Requester 2 has `rsp_ready` = 0 and issues 2 requests. `req_ready[2]` stays 0 afterwards while the others keep being served. Raising `rsp_ready[2]` for one pop re-enables exactly one issue.
- **Invalid operation.** 0x00000000 / 0x00000000 from requester 1. Expect 0x7FC00000 with flags 5'b10000.
- **Tag error.** Inject `div_valid_out` = 1 while no tag is valid. `tag_error` rises the next cycle and stays high, and no FIFO receives a push.
- **Reset mid-flight.** Assert `rst_n` = 0 with 3 operations in flight. All outputs are at reset values immediately, and no `rsp_valid` appears after release.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Package   : fp_pkg
// Purpose   : Shared floating-point types and widths for the FP blocks.
//             Holds the divider result/flag structures used when steering
//             divider output into per-requester result storage.
// Revision  : 1.0  initial release
// ============================================================================
package fp_pkg;

  localparam int FP_W    = 32;  // binary32 operand/result width
  localparam int FLAGS_W = 5;   // IEEE exception flags
  localparam int RM_W    = 3;   // rounding-mode field

  typedef logic [FP_W-1:0] fp_32b_t;

  // Field order matches the divider's flag bus, MSB first:
  // {invalid_operation, division_by_zero, overflow, underflow, inexact}.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_div_flags_t;

  typedef struct packed {
    fp_32b_t       value;
    fp_div_flags_t flags;
  } fp_div_result_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : rr_arbiter
// Purpose   : Combinational round-robin arbiter. Searches the request vector
//             starting one position after the pointer, wrapping around, and
//             grants the first set request.
// Ports     : req   [N-1:0]         request vector
//             ptr   [clog2(N)-1:0]  index of the most recent winner
//             grant [N-1:0]         one-hot grant, or zero when idle
// Revision  : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    // Offsets 1..N visit every index once, ending on ptr itself so a lone
    // requester that just won can win again.
    for (int off = 1; off <= N; off++) begin
      idx = PW'((int'(ptr) + off) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fp_div_scheduler.sv
`default_nettype none
// ============================================================================
// Module    : fp_div_scheduler
// Purpose   : Shares one non-stallable, fixed-latency FP divider among
//             NUM_REQ requesters. Round-robin arbitration issues at most one
//             division per cycle; every issue carries its requester ID down a
//             tag pipeline aligned with the divider, and each result lands in
//             that requester's small result FIFO. A per-requester credit
//             counter guarantees a FIFO slot before issue, so the divider is
//             never back-pressured.
// Ports     : clk, rst_n                 clock, async active-low reset
//             req_valid/req_ready        per-requester request handshake
//             req_in1/req_in2            packed dividends / divisors (32b each)
//             req_rounding_mode          packed rounding modes (3b each)
//             div_valid_in, div_in1,
//             div_in2, div_rounding_mode registered drive to the divider
//             div_out, div_flags,
//             div_valid_out              divider result
//             rsp_valid/rsp_ready        per-requester result handshake
//             rsp_data/rsp_flags         packed FIFO heads
//             tag_error                  sticky divider/tag misalignment
// Revision  : 1.0  initial release
// ============================================================================
module fp_div_scheduler
  import fp_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LATENCY      = 15,
  parameter int RESULT_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,

  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*FP_W-1:0]    req_in1,
  input  logic [NUM_REQ*FP_W-1:0]    req_in2,
  input  logic [NUM_REQ*RM_W-1:0]    req_rounding_mode,

  output logic                       div_valid_in,
  output logic [FP_W-1:0]            div_in1,
  output logic [FP_W-1:0]            div_in2,
  output logic [RM_W-1:0]            div_rounding_mode,
  input  logic [FP_W-1:0]            div_out,
  input  logic [FLAGS_W-1:0]         div_flags,
  input  logic                       div_valid_out,

  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [NUM_REQ*FP_W-1:0]    rsp_data,
  output logic [NUM_REQ*FLAGS_W-1:0] rsp_flags,

  output logic                       tag_error
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RESULT_DEPTH + 1);
  localparam int PTR_W = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;

  localparam logic [CNT_W-1:0] CREDIT_MAX  = CNT_W'(RESULT_DEPTH);
  localparam logic [PTR_W-1:0] FIFO_LAST   = PTR_W'(RESULT_DEPTH - 1);
  localparam logic [ID_W-1:0]  RR_PTR_INIT = ID_W'(NUM_REQ - 1);

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    issue_id;
  logic [FP_W-1:0]    sel_in1;
  logic [FP_W-1:0]    sel_in2;
  logic [RM_W-1:0]    sel_rm;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // While reset is asserted the credit counters already read zero, so without
  // this gate a valid requester would see ready during reset.
  assign req_ready = grant & {NUM_REQ{rst_n}};
  assign accept    = |req_ready;

  always_comb begin
    grant_id = '0;
    sel_in1  = '0;
    sel_in2  = '0;
    sel_rm   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = ID_W'(i);
        sel_in1  = req_in1[i*FP_W +: FP_W];
        sel_in2  = req_in2[i*FP_W +: FP_W];
        sel_rm   = req_rounding_mode[i*RM_W +: RM_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Issue register: operands hold when nothing is accepted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_valid_in      <= 1'b0;
      div_in1           <= '0;
      div_in2           <= '0;
      div_rounding_mode <= '0;
      issue_id          <= '0;
      rr_ptr            <= RR_PTR_INIT;
    end else begin
      div_valid_in <= accept;
      if (accept) begin
        div_in1           <= sel_in1;
        div_in2           <= sel_in2;
        div_rounding_mode <= sel_rm;
        issue_id          <= grant_id;
        rr_ptr            <= grant_id;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Tag pipeline: stage 0 captures the issue register on the same edge the
  // divider samples it, so stage LATENCY-1 lines up with div_valid_out.
  // --------------------------------------------------------------------------
  logic [LATENCY-1:0] tag_valid;
  logic [ID_W-1:0]    tag_id [LATENCY];
  logic               tail_valid;
  logic [ID_W-1:0]    tail_id;

  for (genvar k = 0; k < LATENCY; k++) begin : g_tag
    if (k == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_valid[0] <= 1'b0;
          tag_id[0]    <= '0;
        end else begin
          tag_valid[0] <= div_valid_in;
          tag_id[0]    <= issue_id;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_valid[k] <= 1'b0;
          tag_id[k]    <= '0;
        end else begin
          tag_valid[k] <= tag_valid[k-1];
          tag_id[k]    <= tag_id[k-1];
        end
      end
    end
  end

  assign tail_valid = tag_valid[LATENCY-1];
  assign tail_id    = tag_id[LATENCY-1];

  // Sticky: once the divider and the tag stream disagree, nothing downstream
  // can be trusted without a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_error <= 1'b0;
    end else if (tail_valid != div_valid_out) begin
      tag_error <= 1'b1;
    end
  end

  fp_div_result_t div_result;
  assign div_result = {div_out, div_flags};

  // --------------------------------------------------------------------------
  // Per-requester credit counter and result FIFO
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    logic [CNT_W-1:0] outstanding;
    logic             push;
    logic             pop;
    logic             release_credit;
    fp_div_result_t   mem [RESULT_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    fp_div_result_t   head;

    assign eligible[i]    = req_valid[i] && (outstanding < CREDIT_MAX);
    assign push           = tail_valid &&  div_valid_out && (tail_id == ID_W'(i));
    // A tag whose result never arrived will never occupy the FIFO, so its
    // credit is returned here instead of by a pop.
    assign release_credit = tail_valid && !div_valid_out && (tail_id == ID_W'(i));
    assign pop            = rsp_valid[i] && rsp_ready[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        outstanding <= '0;
      end else begin
        outstanding <= outstanding + CNT_W'(req_ready[i])
                                   - CNT_W'(pop)
                                   - CNT_W'(release_credit);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int e = 0; e < RESULT_DEPTH; e++) begin
          mem[e] <= '0;
        end
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= div_result;
          wr_ptr      <= (wr_ptr == FIFO_LAST) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == FIFO_LAST) ? '0 : rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end

    assign head                              = mem[rd_ptr];
    assign rsp_valid[i]                      = (count != '0);
    assign rsp_data[i*FP_W +: FP_W]          = head.value;
    assign rsp_flags[i*FLAGS_W +: FLAGS_W]   = head.flags;
  end

endmodule : fp_div_scheduler
`default_nettype wire

// File: tb/tb_fp_div_scheduler.sv
`default_nettype none
// ============================================================================
// Module    : tb_fp_div_scheduler
// Purpose   : Self-checking bench for fp_div_scheduler. A fixed-latency
//             divider stand-in closes the loop; a queue-per-requester model
//             predicts grants, issue, result timing and result contents.
// Revision  : 1.0  initial release
// ============================================================================
module tb_fp_div_scheduler;

  localparam int NUM_REQ      = 4;
  localparam int LATENCY      = 15;
  localparam int RESULT_DEPTH = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*32-1:0]  req_in1, req_in2, rsp_data;
  logic [NUM_REQ*3-1:0]   req_rounding_mode;
  logic [NUM_REQ*5-1:0]   rsp_flags;
  logic                   div_valid_in, div_valid_out, tag_error;
  logic [31:0]            div_in1, div_in2, div_out;
  logic [2:0]             div_rounding_mode;
  logic [4:0]             div_flags;

  always #5 clk = ~clk;

  fp_div_scheduler #(
    .NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .RESULT_DEPTH(RESULT_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_rounding_mode(req_rounding_mode),
    .div_valid_in(div_valid_in), .div_in1(div_in1), .div_in2(div_in2),
    .div_rounding_mode(div_rounding_mode),
    .div_out(div_out), .div_flags(div_flags), .div_valid_out(div_valid_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .tag_error(tag_error)
  );

  // Divider stand-in: exact IEEE answers for the directed vectors, a
  // deterministic scramble otherwise (the scheduler only moves bits).
  function automatic logic [36:0] div_model(logic [31:0] a, logic [31:0] b, logic [2:0] rm);
    if (a == 32'h40C00000 && b == 32'h40000000) return {32'h40400000, 5'b00000};
    if (a == 32'h0 && b == 32'h0)               return {32'h7FC00000, 5'b10000};
    return {a ^ {b[15:0], b[31:16]} ^ {29'd0, rm}, a[4:0] ^ b[9:5]};
  endfunction

  logic [LATENCY-1:0] dv_pipe;
  logic [36:0]        dd_pipe [LATENCY];
  logic               inject, suppress;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_pipe <= '0;
      for (int k = 0; k < LATENCY; k++) dd_pipe[k] <= '0;
    end else begin
      dv_pipe    <= {dv_pipe[LATENCY-2:0], div_valid_in};
      dd_pipe[0] <= div_model(div_in1, div_in2, div_rounding_mode);
      for (int k = 1; k < LATENCY; k++) dd_pipe[k] <= dd_pipe[k-1];
    end
  end

  assign div_valid_out       = (dv_pipe[LATENCY-1] & ~suppress) | inject;
  assign {div_out, div_flags} = dd_pipe[LATENCY-1];

  // --------------------------------------------------------------------------
  // Reference model: per-requester queue of outstanding results (in flight
  // plus buffered) with the cycle each becomes visible.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [36:0] res;
    int          due;
  } exp_t;

  exp_t        q [NUM_REQ][$];
  int          cyc, compared, mismatched, rr;
  logic        tag_err_exp, prev_acc;
  logic [31:0] prev_a, prev_b;
  logic [2:0]  prev_rm;
  logic [NUM_REQ-1:0] pending;
  logic [31:0] op_a [NUM_REQ];
  logic [31:0] op_b [NUM_REQ];
  logic [2:0]  op_rm [NUM_REQ];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_op(int i, logic [31:0] a, logic [31:0] b, logic [2:0] rm);
    op_a[i] = a; op_b[i] = b; op_rm[i] = rm; pending[i] = 1'b1;
  endtask

  task automatic new_op(int i);
    set_op(i, $urandom, $urandom, 3'($urandom_range(0, 4)));
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                 = pending[i];
      req_in1[i*32 +: 32]          = op_a[i];
      req_in2[i*32 +: 32]          = op_b[i];
      req_rounding_mode[i*3 +: 3]  = op_rm[i];
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NUM_REQ; i++) q[i].delete();
    rr = NUM_REQ - 1; prev_acc = 1'b0; tag_err_exp = 1'b0; pending = '0;
  endtask

  task automatic check_reset_outputs(string ph);
    check({ph, "/req_ready"},   64'(req_ready), 64'd0);
    check({ph, "/div_valid_in"}, 64'(div_valid_in), 64'd0);
    check({ph, "/div_in1"},     64'(div_in1), 64'd0);
    check({ph, "/div_in2"},     64'(div_in2), 64'd0);
    check({ph, "/div_rm"},      64'(div_rounding_mode), 64'd0);
    check({ph, "/rsp_valid"},   64'(rsp_valid), 64'd0);
    check({ph, "/rsp_data_lo"}, 64'(rsp_data[63:0]), 64'd0);
    check({ph, "/rsp_data_hi"}, 64'(rsp_data[127:64]), 64'd0);
    check({ph, "/rsp_flags"},   64'(rsp_flags), 64'd0);
    check({ph, "/tag_error"},   64'(tag_error), 64'd0);
  endtask

  // One cycle: apply inputs at the negedge, compare against the model,
  // advance the model by the handshakes it predicts, then step the clock.
  task automatic tick();
    int             g, idx;
    logic [NUM_REQ-1:0] exp_ready;
    logic           ev;
    exp_t           e;
    drive();
    #1;
    g = -1;
    exp_ready = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (rr + off) % NUM_REQ;
      if (g < 0 && pending[idx] && q[idx].size() < RESULT_DEPTH) g = idx;
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("div_valid_in", 64'(div_valid_in), 64'(prev_acc));
    if (prev_acc) begin
      check("div_in1", 64'(div_in1), 64'(prev_a));
      check("div_in2", 64'(div_in2), 64'(prev_b));
      check("div_rm",  64'(div_rounding_mode), 64'(prev_rm));
    end
    check("tag_error", 64'(tag_error), 64'(tag_err_exp));
    for (int i = 0; i < NUM_REQ; i++) begin
      ev = 1'b0;
      if (q[i].size() > 0) begin
        if (q[i][0].due <= cyc) ev = 1'b1;
      end
      check($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'(ev));
      if (ev) begin
        check($sformatf("rsp_data[%0d]", i),  64'(rsp_data[i*32 +: 32]), 64'(q[i][0].res[36:5]));
        check($sformatf("rsp_flags[%0d]", i), 64'(rsp_flags[i*5 +: 5]),  64'(q[i][0].res[4:0]));
        if (rsp_ready[i]) void'(q[i].pop_front());
      end
    end
    prev_acc = (g >= 0);
    if (g >= 0) begin
      e.res = div_model(op_a[g], op_b[g], op_rm[g]);
      e.due = cyc + LATENCY + 2;
      q[g].push_back(e);
      prev_a = op_a[g]; prev_b = op_b[g]; prev_rm = op_rm[g];
      pending[g] = 1'b0;
      rr = g;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    compared = 0; mismatched = 0; cyc = 0;
    inject = 1'b0; suppress = 1'b0; rsp_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_rm[i] = '0;
    end
    reset_model();
    drive();
    rst_n = 1'b0;

    // Reset values, with a requester asserting valid.
    @(negedge clk);
    set_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 3'd1);
    drive();
    #1;
    check_reset_outputs("reset");
    pending = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single request: 6.0 / 2.0 = 3.0, visible LATENCY+2 cycles after accept.
    set_op(0, 32'h40C00000, 32'h40000000, 3'd0);
    repeat (LATENCY + 2) tick();
    check("single/rsp_valid", 64'(rsp_valid[0]), 64'd1);
    check("single/rsp_data",  64'(rsp_data[31:0]), 64'h40400000);
    check("single/rsp_flags", 64'(rsp_flags[4:0]), 64'd0);
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready = '0;

    // Invalid operation: 0 / 0 -> quiet NaN with invalid flag.
    set_op(1, 32'h0, 32'h0, 3'd0);
    repeat (LATENCY + 2) tick();
    check("invalid/rsp_data",  64'(rsp_data[63:32]), 64'h7FC00000);
    check("invalid/rsp_flags", 64'(rsp_flags[9:5]), 64'b10000);
    rsp_ready[1] = 1'b1;
    tick();

    // Fairness: everyone valid, everyone draining.
    rsp_ready = '1;
    repeat (60) begin
      for (int i = 0; i < NUM_REQ; i++) if (!pending[i]) new_op(i);
      tick();
    end
    repeat (LATENCY + 6) tick();

    // Credit stall on requester 2.
    rsp_ready = 4'b1011;
    repeat (50) begin
      for (int i = 0; i < NUM_REQ; i++) if (!pending[i]) new_op(i);
      tick();
    end
    drive();
    #1;
    check("stall/req_ready2", 64'(req_ready[2]), 64'd0);
    rsp_ready[2] = 1'b1;
    tick();
    rsp_ready[2] = 1'b0;
    repeat (LATENCY + 6) tick();
    pending = '0;
    rsp_ready = '1;
    repeat (LATENCY + 8) tick();

    // Tag error: a result with no tag behind it.
    inject = 1'b1;
    tick();
    inject = 1'b0;
    tag_err_exp = 1'b1;
    repeat (4) tick();

    // Reset with three operations in flight.
    set_op(0, $urandom, $urandom, 3'd2);
    set_op(1, $urandom, $urandom, 3'd3);
    set_op(2, $urandom, $urandom, 3'd4);
    repeat (5) tick();
    set_op(3, $urandom, $urandom, 3'd0);
    drive();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midflight");
    reset_model();
    drive();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LATENCY + 5) tick();

    // A tag whose result is lost returns its credit.
    rsp_ready[3] = 1'b0;
    set_op(3, $urandom, $urandom, 3'd1);
    repeat (LATENCY + 1) tick();
    suppress = 1'b1;
    tick();
    suppress = 1'b0;
    void'(q[3].pop_front());
    tag_err_exp = 1'b1;
    set_op(3, $urandom, $urandom, 3'd0);
    tick();
    set_op(3, $urandom, $urandom, 3'd2);
    tick();
    check("release/outstanding3", 64'(q[3].size()), 64'd2);
    rsp_ready = '1;
    repeat (LATENCY + 4) tick();

    // Random traffic.
    repeat (500) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!pending[i] && $urandom_range(0, 1) == 1) new_op(i);
      rsp_ready = 4'($urandom);
      tick();
    end
    rsp_ready = '1;
    repeat (3 * LATENCY + 20) tick();
    check("drain/rsp_valid", 64'(rsp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_fp_div_scheduler
`default_nettype wire
